paddle_ctrl: RTL
================

Name: paddle_ctrl

Overview:
Responder for the main FSM's object-select handshake. When SEL equals its code, it:
- erases the paddle from the framebuffer,
- moves the paddle one step from the button inputs,
- redraws the paddle,
- raises DONE and holds it until the main FSM deselects it.

It sits between the main FSM, the VGA adapter's pixel-write port and the ball logic, which reads PADDLE_X for collisions.

Parameters:
SCREEN_W, 160, screen width in pixels
PAD_W, 24, paddle width in pixels
PAD_H, 3, paddle height in pixels
PAD_Y, 112, top row of paddle
STEP, 2, pixels moved per update
MY_CODE, 2'd1, SEL value that activates this block
PAD_COLOUR, 3'b111, paddle draw colour
BG_COLOUR, 3'b000, erase colour

Ports:
CLK  in  1  system clock (50 MHz)
RESET_N  in  1  async active-low reset
SEL  in  2  object-select from main FSM (0 idle, 1 paddle, 2 ball)
BTN_LEFT  in  1  move-left request, active-high, already synchronised
BTN_RIGHT  in  1  move-right request, active-high, already synchronised
DONE  out  1  update complete; feeds IN_SIG[0] of main FSM
PLOT  out  1  pixel write enable to VGA adapter
X  out  8  pixel column
Y  out  7  pixel row
COLOUR  out  3  pixel colour
PADDLE_X  out  8  current paddle left edge

Behaviour:
- Reset: RESET_N is asynchronous, active-low; clock is CLK.
  - State goes to IDLE.
  - pad_x = (SCREEN_W-PAD_W)/2 = 68.
  - Scan counters are 0.
  - DONE=0, PLOT=0, X=0, Y=0, COLOUR=0.
  - Reset asserted mid-scan aborts immediately; no further PLOT.
- States: IDLE, ERASE, MOVE, DRAW, FIN.
- IDLE: stays until SEL==MY_CODE is sampled, then goes to ERASE.
- ERASE:
  - Each cycle: PLOT=1, X=pad_x+col, Y=PAD_Y+row, COLOUR=BG_COLOUR.
  - col increments 0..PAD_W-1; on wrap, row increments 0..PAD_H-1.
  - After the last pixel (col=PAD_W-1, row=PAD_H-1), goes to MOVE.
  - Duration is exactly PAD_W*PAD_H = 72 cycles.
- MOVE: one cycle, PLOT=0. Buttons are sampled only in this cycle.
  - Left only: pad_x = max(0, pad_x-STEP), saturating, no underflow wrap.
  - Right only: pad_x = min(SCREEN_W-PAD_W, pad_x+STEP), saturating.
  - Both or neither: pad_x unchanged.
  - Arithmetic is 9-bit to detect under/overflow before clamping.
  - Next state is DRAW.
- DRAW: same scan as ERASE using the new pad_x and PAD_COLOUR; 72 cycles, then FIN.
- FIN:
  - DONE = (SEL==MY_CODE), combinational from state and SEL.
  - When SEL!=MY_CODE, returns to IDLE the next cycle.
  - DONE is therefore low in the same cycle SEL deselects.
- Latency: DONE first high 146 cycles after the IDLE cycle in which SEL matched (72+1+72+1).
- Deselect mid-operation: if SEL leaves MY_CODE during ERASE, MOVE or DRAW, the sequence still completes, so the paddle is never left half-drawn. FIN then returns directly to IDLE with DONE never asserted.
- Scan counters reset to 0 on entry to ERASE and DRAW.
- PADDLE_X:
  - Registered copy of pad_x.
  - Changes only at the end of the MOVE cycle.
  - Stable while SEL selects the ball.
- X/Y/COLOUR hold their last values when PLOT=0; the adapter ignores them then.

Optional Feature:
PADDLE_ACCEL_EN
- Defined:
  - 2-bit saturating hold_cnt increments in MOVE when the same single direction is pressed as in the previous MOVE.
  - hold_cnt clears on direction change, both pressed, neither pressed, or reset.
  - Step is 2*STEP when hold_cnt==3, else STEP; clamping rules are unchanged.
- Undefined: fixed STEP; no hold_cnt register.

Decomposition:
- Shared package breakout_pkg holds:
  - SCREEN_W/SCREEN_H,
  - SEL codes SEL_IDLE=2'd0, SEL_PADDLE=2'd1, SEL_BALL=2'd2,
  - colour constants,
  - X/Y width constants.
- Sub-module rect_scanner: col/row counter with start/busy/last outputs and PLOT/X/Y generation from base coordinates and W/H parameters. The ball block will reuse it.

Test Plan:
- Reset: RESET_N low mid-run -> DONE=0, PLOT=0, PADDLE_X=68; after release with SEL=0, PLOT stays 0.
- SEL=1, BTN_RIGHT=1 at pad_x=68 -> 72 PLOTs with COLOUR=0 at X 68..91, Y 112..114; then 72 PLOTs with COLOUR=7 at X 70..93; PADDLE_X=70; DONE high on cycle 146.
- Saturation:
  - pad_x=1, BTN_LEFT -> PADDLE_X=0.
  - pad_x=135, BTN_RIGHT -> 136.
  - At 136, BTN_RIGHT -> stays 136.
- Both buttons held -> PADDLE_X unchanged; erase and draw coordinates identical.
- Handshake:
  - DONE stays high while SEL=1; SEL->0 gives DONE=0 the same cycle, IDLE next; SEL=2 causes no PLOT.
  - SEL dropped during ERASE: the full 144-PLOT sequence completes and DONE is never high.
- PADDLE_ACCEL_EN: BTN_RIGHT held for 5 updates from 68 -> PADDLE_X 70, 72, 74, 78, 82.

Source files
------------

// File: rtl/breakout_pkg.sv
// ---------------------------------------------------------------------------
// breakout_pkg
// Shared definitions for the breakout game blocks: screen geometry,
// object-select codes used by the main FSM handshake, colour constants,
// pixel coordinate widths, and the paddle controller state encoding.
// ---------------------------------------------------------------------------
package breakout_pkg;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;

  localparam int X_W      = 8;
  localparam int Y_W      = 7;
  localparam int COLOUR_W = 3;

  localparam logic [1:0] SEL_IDLE   = 2'd0;
  localparam logic [1:0] SEL_PADDLE = 2'd1;
  localparam logic [1:0] SEL_BALL   = 2'd2;

  localparam logic [COLOUR_W-1:0] COLOUR_BLACK = 3'b000;
  localparam logic [COLOUR_W-1:0] COLOUR_WHITE = 3'b111;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ERASE = 3'd1,
    S_MOVE  = 3'd2,
    S_DRAW  = 3'd3,
    S_FIN   = 3'd4
  } pad_state_e;

endpackage

// File: rtl/rect_scanner.sv
// ---------------------------------------------------------------------------
// rect_scanner
// Walks a W x H rectangle one pixel per clock, column-major within a row,
// starting from (base_x, base_y). A start pulse clears the counters and
// makes the scanner busy from the next cycle; busy stays high for exactly
// W*H cycles. x/y hold the last plotted coordinate while idle.
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   start            begin a new scan (counters restart at 0)
//   base_x, base_y   top-left corner of the rectangle
//   busy             scan in progress
//   last             current pixel is the final one of the scan
//   plot             pixel write enable (same as busy)
//   x, y             current pixel coordinate
// ---------------------------------------------------------------------------
module rect_scanner
  import breakout_pkg::*;
#(
  parameter int W = 24,
  parameter int H = 3
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [X_W-1:0] base_x,
  input  logic [Y_W-1:0] base_y,
  output logic           busy,
  output logic           last,
  output logic           plot,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y
);

  localparam logic [X_W-1:0] COL_LAST = X_W'(W - 1);
  localparam logic [Y_W-1:0] ROW_LAST = Y_W'(H - 1);

  logic           busy_q, busy_d;
  logic [X_W-1:0] col_q, col_d;
  logic [Y_W-1:0] row_q, row_d;
  logic [X_W-1:0] x_q, x_d;
  logic [Y_W-1:0] y_q, y_d;

  always_comb begin
    busy_d = busy_q;
    col_d  = col_q;
    row_d  = row_q;
    last   = busy_q && (col_q == COL_LAST) && (row_q == ROW_LAST);

    if (start) begin
      busy_d = 1'b1;
      col_d  = '0;
      row_d  = '0;
    end else if (busy_q) begin
      if (col_q == COL_LAST) begin
        col_d = '0;
        if (row_q == ROW_LAST) begin
          row_d  = '0;
          busy_d = 1'b0;
        end else begin
          row_d = row_q + 1'b1;
        end
      end else begin
        col_d = col_q + 1'b1;
      end
    end

    // Coordinates are live while scanning and frozen otherwise.
    x_d = busy_q ? (base_x + col_q) : x_q;
    y_d = busy_q ? (base_y + row_q) : y_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      col_q  <= '0;
      row_q  <= '0;
      x_q    <= '0;
      y_q    <= '0;
    end else begin
      busy_q <= busy_d;
      col_q  <= col_d;
      row_q  <= row_d;
      x_q    <= x_d;
      y_q    <= y_d;
    end
  end

  assign busy = busy_q;
  assign plot = busy_q;
  assign x    = x_d;
  assign y    = y_d;

endmodule

// File: rtl/paddle_ctrl.sv
// ---------------------------------------------------------------------------
// paddle_ctrl
// Responds to the main FSM's object-select handshake. When SEL equals
// MY_CODE it erases the paddle, moves it one step from the buttons,
// redraws it, then holds DONE until the main FSM deselects it. Once
// started, the erase/move/draw sequence always completes so the paddle is
// never left half-drawn.
//
// Ports:
//   CLK, RESET_N          clock, asynchronous active-low reset
//   SEL                   object-select from main FSM
//   BTN_LEFT, BTN_RIGHT   synchronised move requests, sampled in MOVE only
//   DONE                  update complete (high in FIN while selected)
//   PLOT, X, Y, COLOUR    pixel write port to the VGA adapter
//   PADDLE_X              current paddle left edge, for ball collisions
//
// Build option: define PADDLE_ACCEL_EN to double the step once the same
// single direction has been held for three consecutive updates.
// ---------------------------------------------------------------------------
module paddle_ctrl #(
  parameter int         SCREEN_W   = breakout_pkg::SCREEN_W,
  parameter int         PAD_W      = 24,
  parameter int         PAD_H      = 3,
  parameter int         PAD_Y      = 112,
  parameter int         STEP       = 2,
  parameter logic [1:0] MY_CODE    = breakout_pkg::SEL_PADDLE,
  parameter logic [2:0] PAD_COLOUR = breakout_pkg::COLOUR_WHITE,
  parameter logic [2:0] BG_COLOUR  = breakout_pkg::COLOUR_BLACK
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic [1:0] SEL,
  input  logic       BTN_LEFT,
  input  logic       BTN_RIGHT,
  output logic       DONE,
  output logic       PLOT,
  output logic [7:0] X,
  output logic [6:0] Y,
  output logic [2:0] COLOUR,
  output logic [7:0] PADDLE_X
);

  import breakout_pkg::*;

  localparam logic [8:0] X_MAX9  = 9'(SCREEN_W - PAD_W);
  localparam logic [7:0] X_START = 8'((SCREEN_W - PAD_W) / 2);

  pad_state_e state_q, state_d;
  logic [7:0] pad_x_q, pad_x_d;
  logic [2:0] colour_q, colour_d;

  logic       scan_start, scan_busy, scan_last;
  logic       left_only, right_only;
  logic [8:0] step9, sum9, diff9;

  assign left_only  = BTN_LEFT & ~BTN_RIGHT;
  assign right_only = BTN_RIGHT & ~BTN_LEFT;

`ifdef PADDLE_ACCEL_EN
  // Direction of the previous MOVE: 2'b01 left, 2'b10 right, 2'b00 none/both.
  logic [1:0] hold_cnt_q, hold_cnt_d;
  logic [1:0] last_dir_q, last_dir_d;
  logic [1:0] dir_now;

  always_comb begin
    dir_now    = {right_only, left_only};
    hold_cnt_d = hold_cnt_q;
    last_dir_d = last_dir_q;
    if (state_q == S_MOVE) begin
      last_dir_d = dir_now;
      if ((dir_now != 2'b00) && (dir_now == last_dir_q))
        hold_cnt_d = (hold_cnt_q == 2'd3) ? 2'd3 : hold_cnt_q + 2'd1;
      else
        hold_cnt_d = 2'd0;
    end
    // The count after this MOVE decides the step, so the fourth
    // consecutive press is the first accelerated one.
    step9 = (hold_cnt_d == 2'd3) ? 9'(2 * STEP) : 9'(STEP);
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      hold_cnt_q <= 2'd0;
      last_dir_q <= 2'b00;
    end else begin
      hold_cnt_q <= hold_cnt_d;
      last_dir_q <= last_dir_d;
    end
  end
`else
  assign step9 = 9'(STEP);
`endif

  // 9-bit arithmetic so underflow shows up as bit 8 and overflow as a
  // value above the right-hand limit.
  assign sum9  = {1'b0, pad_x_q} + step9;
  assign diff9 = {1'b0, pad_x_q} - step9;

  // The scan is launched one cycle ahead so the scanner is busy exactly
  // while the FSM sits in ERASE or DRAW.
  assign scan_start = ((state_q == S_IDLE) && (SEL == MY_CODE)) || (state_q == S_MOVE);

  always_comb begin
    state_d = state_q;
    pad_x_d = pad_x_q;
    DONE    = 1'b0;

    case (state_q)
      S_IDLE:  if (SEL == MY_CODE) state_d = S_ERASE;
      S_ERASE: if (scan_last) state_d = S_MOVE;
      S_MOVE: begin
        state_d = S_DRAW;
        if (left_only)
          pad_x_d = diff9[8] ? 8'd0 : diff9[7:0];
        else if (right_only)
          pad_x_d = (sum9 > X_MAX9) ? X_MAX9[7:0] : sum9[7:0];
      end
      S_DRAW:  if (scan_last) state_d = S_FIN;
      S_FIN: begin
        DONE = (SEL == MY_CODE);
        if (SEL != MY_CODE) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    colour_d = scan_busy ? ((state_q == S_DRAW) ? PAD_COLOUR : BG_COLOUR) : colour_q;
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q  <= S_IDLE;
      pad_x_q  <= X_START;
      colour_q <= 3'b000;
    end else begin
      state_q  <= state_d;
      pad_x_q  <= pad_x_d;
      colour_q <= colour_d;
    end
  end

  rect_scanner #(
    .W (PAD_W),
    .H (PAD_H)
  ) u_scan (
    .clk    (CLK),
    .rst_n  (RESET_N),
    .start  (scan_start),
    .base_x (pad_x_q),
    .base_y (7'(PAD_Y)),
    .busy   (scan_busy),
    .last   (scan_last),
    .plot   (PLOT),
    .x      (X),
    .y      (Y)
  );

  assign COLOUR   = colour_d;
  assign PADDLE_X = pad_x_q;

endmodule
